mem_1r1w_masked_32x136_sched: RTL
=================================

// Module: mem_1r1w_masked_32x136_sched
// PURPOSE
//  Front-end controller for the mem_1r1w_masked_32x136 macro wrapper. After reset it zero-fills all 32 entries.
//  It then shares the single masked write port between two requesters (A, B) with round-robin arbitration.
//  The read port is exposed as valid/ready with a backpressured, one-cycle-latency response.
//  Sits between core-side producers/consumers and the memory instance.
// PARAMETERS
//  DEPTH     32   entries in the memory; must be a power of 2
//  AW        5    address width, log2(DEPTH)
//  WIDTH     136  data width
//  MASK_GRAN 8    bits per mask lane
//  MW        17   mask width, ceil(WIDTH/MASK_GRAN)
// PORTS
//  clock      in   1      single clock for the controller and the memory (R0_clk and W0_clk tied to it)
//  reset      in   1      asynchronous, active-high
//  init_busy  out  1      high while the zero-fill sequence runs
//  wa_valid   in   1      requester A write request
//  wa_ready   out  1      requester A grant; write is accepted when wa_valid&&wa_ready
//  wa_addr    in   AW     requester A write address
//  wa_data    in   WIDTH  requester A write data
//  wa_mask    in   MW     requester A lane mask; 1 = write lane
//  wb_*       -    -      requester B; same five signals as A
//  rd_valid   in   1      read request
//  rd_ready   out  1      read request accepted when rd_valid&&rd_ready
//  rd_addr    in   AW     read address
//  rsp_valid  out  1      read response valid
//  rsp_ready  in   1      response consumed when rsp_valid&&rsp_ready
//  rsp_data   out  WIDTH  read response data
//  R0_addr/R0_en/R0_data  out/out/in   AW/1/WIDTH  memory read port
//  W0_addr/W0_en/W0_data/W0_mask  out  AW/1/WIDTH/MW  memory write port
// BEHAVIOUR
//  - State machine: INIT -> RUN. Reset (asynchronous, any time) forces INIT, init_ptr=0, rr_ptr=A and
//    rsp_valid=0. Reset also clears the bypass registers.
//  - INIT: each cycle W0_en=1, W0_addr=init_ptr, W0_data=0, W0_mask=all ones, then init_ptr++.
//    When init_ptr==DEPTH-1 is written, the next state is RUN. INIT lasts exactly DEPTH cycles.
//    init_busy=1; wa_ready=wb_ready=rd_ready=0; R0_en=0.
//  - RUN: init_busy=0. Write arbitration is combinational in the same cycle.
//    Only one valid: that requester is granted. Both valid: the rr_ptr side is granted.
//    rr_ptr updates to the non-granted side only when both were valid. Idle and single grants leave rr_ptr unchanged.
//    W0_en = grant, and the W0_* buses carry the granted requester's addr/data/mask.
//    Neither valid: W0_en=0, W0_* = 0.
//  - A write with an all-zero mask is still granted and consumed; W0_en=1, so the memory changes nothing.
//  - Read: rd_ready = RUN && (!rsp_valid || rsp_ready). R0_en = rd_valid && rd_ready, R0_addr = rd_addr.
//    rsp_valid is set on the cycle after acceptance.
//    rsp_valid clears on rsp_valid&&rsp_ready with no new acceptance; it stays set if a back-to-back read is accepted.
//    Throughput: 1 read/cycle when rsp_ready is held high.
//  - rsp_data = R0_data. The macro holds QA while CENA is inactive, so data stays stable under backpressure.
//    rsp_data is don't-care when rsp_valid=0.
//  - Read and write to different addresses in the same cycle proceed independently.
//  - Reset during INIT restarts the fill at address 0. Reset with rsp_valid=1 drops the response; no retry.
//  - init_ptr is AW bits wide. The INIT->RUN exit uses ptr==DEPTH-1, not wrap detection.
// CONFIGURATION
//  MEM_SCHED_BYPASS_EN defined: same-cycle read/write collision forwarding.
//    Collision: a read is accepted in the same cycle as a granted write with R0_addr==W0_addr.
//    On a collision, register byp_hit=1, byp_data=W0_data and byp_mask=W0_mask.
//    The response returns the post-write value: lanes with byp_mask=1 take byp_data, other lanes take R0_data.
//    byp_* registers are loaded only on read acceptance and held under backpressure.
//  MEM_SCHED_BYPASS_EN undefined: no forwarding logic and rsp_data = R0_data.
//    Same-address collisions return undefined data; callers must avoid them.
// TESTING
//  1 Reset release -> init_busy=1 for exactly 32 cycles; W0_addr steps 0..31 with data=0 and mask=17'h1FFFF.
//    Afterwards, reading every address returns 136'h0.
//  2 RUN, wa_valid and wb_valid held high for 4 cycles -> grants A,B,A,B.
//    Then only wb_valid for 2 cycles -> B,B. rr_ptr is unchanged, so the next contention grants A.
//  3 Write A addr 5, data all 1s, mask 17'h00001; later read addr 5 -> rsp_data = 136'hFF.
//  4 Read addr 3 accepted with rsp_ready=0 for 3 cycles -> rsp_valid stays 1, rsp_data stable, rd_ready=0.
//    rsp_ready=1 together with a new rd_valid -> back-to-back acceptance and rsp_valid stays 1.
//  5 Assert reset mid-INIT (ptr=12) and mid-response -> rsp_valid=0 immediately.
//    After release the fill restarts at address 0 and lasts 32 cycles.
//  6 (BYPASS_EN) addr 7 holds 0. Same-cycle write of 136'hAB.. with mask 17'h00003 and read of addr 7
//    -> rsp_data[15:0]=16'hABAB, rsp_data[135:16]=0.

Source files
------------

// File: rtl/mem_1r1w_masked_32x136_sched_if.sv
// Bus bundle between core-side requesters, the scheduler and the 32x136 masked memory macro.
// The slave modport is the scheduler's view; master is the environment (requesters + macro).
interface mem_1r1w_masked_32x136_sched_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned WIDTH = 136,
  parameter int unsigned MW    = 17
) ();
  logic             init_busy;

  logic             wa_valid;
  logic             wa_ready;
  logic [AW-1:0]    wa_addr;
  logic [WIDTH-1:0] wa_data;
  logic [MW-1:0]    wa_mask;

  logic             wb_valid;
  logic             wb_ready;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [MW-1:0]    wb_mask;

  logic             rd_valid;
  logic             rd_ready;
  logic [AW-1:0]    rd_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  logic [AW-1:0]    R0_addr;
  logic             R0_en;
  logic [WIDTH-1:0] R0_data;

  logic [AW-1:0]    W0_addr;
  logic             W0_en;
  logic [WIDTH-1:0] W0_data;
  logic [MW-1:0]    W0_mask;

  modport slave (
    output init_busy,
    input  wa_valid, wa_addr, wa_data, wa_mask,
    output wa_ready,
    input  wb_valid, wb_addr, wb_data, wb_mask,
    output wb_ready,
    input  rd_valid, rd_addr, rsp_ready,
    output rd_ready, rsp_valid, rsp_data,
    output R0_addr, R0_en,
    input  R0_data,
    output W0_addr, W0_en, W0_data, W0_mask
  );

  modport master (
    input  init_busy,
    output wa_valid, wa_addr, wa_data, wa_mask,
    input  wa_ready,
    output wb_valid, wb_addr, wb_data, wb_mask,
    input  wb_ready,
    output rd_valid, rd_addr, rsp_ready,
    input  rd_ready, rsp_valid, rsp_data,
    input  R0_addr, R0_en,
    output R0_data,
    input  W0_addr, W0_en, W0_data, W0_mask
  );
endinterface

// File: rtl/mem_1r1w_masked_32x136_sched.sv
// Zero-fill, round-robin write arbitration (A/B) and valid/ready read port for the 32x136 masked macro.
// Define MEM_SCHED_BYPASS_EN to forward a same-cycle, same-address write into the read response.
module mem_1r1w_masked_32x136_sched #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned WIDTH     = 136,
  parameter int unsigned MASK_GRAN = 8,
  parameter int unsigned MW        = (WIDTH + MASK_GRAN - 1) / MASK_GRAN
) (
  input  logic                            clock,
  input  logic                            reset,
  mem_1r1w_masked_32x136_sched_if.slave   bus
);

  typedef enum logic {S_INIT, S_RUN} state_e;
  typedef enum logic {RR_A, RR_B} rr_e;

  state_e        state_q, state_d;
  logic [AW-1:0] init_ptr_q, init_ptr_d;
  rr_e           rr_q, rr_d;
  logic          rsp_valid_q, rsp_valid_d;

  logic             run;
  logic             grant_a, grant_b;
  logic             rd_ready, rd_acc;
  logic             w_en;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic [MW-1:0]    w_mask;

`ifdef MEM_SCHED_BYPASS_EN
  logic             byp_hit_q, byp_hit_d;
  logic [WIDTH-1:0] byp_data_q, byp_data_d;
  logic [MW-1:0]    byp_mask_q, byp_mask_d;
  logic [WIDTH-1:0] rsp_data;
`endif

  always_comb begin
    run     = (state_q == S_RUN);
    grant_a = run && bus.wa_valid && (!bus.wb_valid || (rr_q == RR_A));
    grant_b = run && bus.wb_valid && (!bus.wa_valid || (rr_q == RR_B));

    rd_ready = run && (!rsp_valid_q || bus.rsp_ready);
    rd_acc   = bus.rd_valid && rd_ready;

    w_en   = 1'b0;
    w_addr = '0;
    w_data = '0;
    w_mask = '0;
    if (!run) begin
      w_en   = 1'b1;
      w_addr = init_ptr_q;
      w_mask = '1;
    end else if (grant_a) begin
      w_en   = 1'b1;
      w_addr = bus.wa_addr;
      w_data = bus.wa_data;
      w_mask = bus.wa_mask;
    end else if (grant_b) begin
      w_en   = 1'b1;
      w_addr = bus.wb_addr;
      w_data = bus.wb_data;
      w_mask = bus.wb_mask;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (!run) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == AW'(DEPTH - 1)) state_d = S_RUN;
    end

    // The pointer only moves on contention, to the side that lost.
    rr_d = rr_q;
    if (grant_a && bus.wb_valid)      rr_d = RR_B;
    else if (grant_b && bus.wa_valid) rr_d = RR_A;

    rsp_valid_d = rsp_valid_q;
    if (rd_acc)             rsp_valid_d = 1'b1;
    else if (bus.rsp_ready) rsp_valid_d = 1'b0;
  end

`ifdef MEM_SCHED_BYPASS_EN
  always_comb begin
    byp_hit_d  = byp_hit_q;
    byp_data_d = byp_data_q;
    byp_mask_d = byp_mask_q;
    if (rd_acc) begin
      byp_hit_d  = w_en && (w_addr == bus.rd_addr);
      byp_data_d = w_data;
      byp_mask_d = w_mask;
    end
  end

  // Lanes written in the colliding cycle come from the captured write; the rest from the macro.
  always_comb begin
    rsp_data = bus.R0_data;
    if (byp_hit_q) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (byp_mask_q[b / MASK_GRAN]) rsp_data[b] = byp_data_q[b];
      end
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      init_ptr_q  <= '0;
      rr_q        <= RR_A;
      rsp_valid_q <= 1'b0;
`ifdef MEM_SCHED_BYPASS_EN
      byp_hit_q   <= 1'b0;
      byp_data_q  <= '0;
      byp_mask_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef MEM_SCHED_BYPASS_EN
      byp_hit_q   <= byp_hit_d;
      byp_data_q  <= byp_data_d;
      byp_mask_q  <= byp_mask_d;
`endif
    end
  end

  assign bus.init_busy = (state_q == S_INIT);
  assign bus.wa_ready  = grant_a;
  assign bus.wb_ready  = grant_b;
  assign bus.rd_ready  = rd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.R0_en     = rd_acc;
  assign bus.R0_addr   = bus.rd_addr;
  assign bus.W0_en     = w_en;
  assign bus.W0_addr   = w_addr;
  assign bus.W0_data   = w_data;
  assign bus.W0_mask   = w_mask;
`ifdef MEM_SCHED_BYPASS_EN
  assign bus.rsp_data  = rsp_data;
`else
  assign bus.rsp_data  = bus.R0_data;
`endif

endmodule
